// File: rtl/nibble_serial_adder.sv
// Serial wide adder: adds two 4*NIBBLES-bit operands one nibble per clock through
// a single 4-bit ripple-carry adder, registering the inter-nibble carry.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] w_carry;

  assign w_carry[0] = cin;
  assign cout       = w_carry[4];

  for (genvar i = 0; i < 4; i++) begin : gBit
    full_adder uFa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (w_carry[i]),
      .sum (sum[i]),
      .cout(w_carry[i+1])
    );
  end
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 overflow
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_sa;
  logic [W-1:0]    r_sb;
  logic [W-1:0]    r_res;
  logic            r_cr;
  logic [KW-1:0]   r_k;
  logic            r_aMsb;
  logic            r_bMsb;
  logic            r_busy;
  logic            r_done;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic [3:0]      w_sum4;
  logic            w_cout4;
  logic [W+3:0]    w_cat;
  logic [W-1:0]    w_resNext;

  ripple_adder4 uAdder (
    .a   (r_sa[3:0]),
    .b   (r_sb[3:0]),
    .cin (r_cr),
    .sum (w_sum4),
    .cout(w_cout4)
  );

  // New nibble enters at the top; after the last nibble the word is in order.
  assign w_cat     = {w_sum4, r_res};
  assign w_resNext = W'(w_cat >> 4);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_cr    <= 1'b0;
      r_k     <= '0;
      r_aMsb  <= 1'b0;
      r_bMsb  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_cr    <= cin;
            r_k     <= '0;
            r_aMsb  <= a[W-1];
            r_bMsb  <= b[W-1];
            r_state <= RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_res <= w_resNext;
          r_cr  <= w_cout4;
          r_sa  <= r_sa >> 4;
          r_sb  <= r_sb >> 4;
          r_k   <= r_k + 1'b1;
          // Outputs load from the next-state values so they are valid with done.
          if (r_k == K_LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= w_resNext;
            r_cout  <= w_cout4;
            r_ovf   <= (r_aMsb == r_bMsb) && (w_resNext[W-1] != r_aMsb);
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder with NIBBLES=4.

module tb_nibble_serial_adder;
  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int checkCount = 0;
  int errorCount = 0;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .cin     (cin),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents operands with start for one edge; returns at the negedge of cycle 1.
  task automatic applyStimulus(input logic [15:0] aIn, input logic [15:0] bIn,
                               input logic cinIn);
    @(negedge clk);
    a     = aIn;
    b     = bIn;
    cin   = cinIn;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done is seen, bounded so a stuck design still finishes.
  task automatic waitDone(input int startCount, output int cycles);
    cycles = startCount;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic countDones(input int window, output int seen);
    seen = 0;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
  endtask

  task automatic runAdd(input string tag, input logic [15:0] aIn, input logic [15:0] bIn,
                        input logic cinIn, input logic [15:0] expSum,
                        input logic expCout, input logic expOvf);
    int lat;
    applyStimulus(aIn, bIn, cinIn);
    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
    waitDone(1, lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'd5);
    checkOutput({tag, " sum"}, 32'(sum), 32'(expSum));
    checkOutput({tag, " cout"}, 32'(cout), 32'(expCout));
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(expOvf));
    @(negedge clk);
    checkOutput({tag, " done pulse"}, 32'(done), 32'd0);
    checkOutput({tag, " sum hold"}, 32'(sum), 32'(expSum));
  endtask

  initial begin
    int lat;
    int seen;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset sum", 32'(sum), 32'd0);
    checkOutput("reset cout", 32'(cout), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    runAdd("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    runAdd("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    runAdd("ripple cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    runAdd("ovf pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    runAdd("ovf neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    runAdd("mixed", 16'hA5C3, 16'h1E2F, 1'b1, 16'hC3F3, 1'b0, 1'b0);

    // Start requests during RUN must be ignored.
    applyStimulus(16'h0001, 16'h0001, 1'b0);
    start = 1'b1;
    a     = 16'hAAAA;
    b     = 16'hAAAA;
    repeat (3) @(negedge clk);
    start = 1'b0;
    waitDone(4, lat);
    checkOutput("busy-start latency", 32'(lat), 32'd5);
    checkOutput("busy-start sum", 32'(sum), 32'h0002);
    countDones(10, seen);
    checkOutput("busy-start extra done", 32'(seen), 32'd0);

    // Back-to-back: new start presented in the DONE cycle.
    applyStimulus(16'h0011, 16'h0022, 1'b0);
    waitDone(1, lat);
    checkOutput("b2b first sum", 32'(sum), 32'h0033);
    a     = 16'h1000;
    b     = 16'h0234;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b busy", 32'(busy), 32'd1);
    checkOutput("b2b sum held", 32'(sum), 32'h0033);
    waitDone(1, lat);
    checkOutput("b2b spacing", 32'(lat), 32'd5);
    checkOutput("b2b sum", 32'(sum), 32'h1234);

    // Reset in cycle 2 of a RUN discards the operation.
    applyStimulus(16'h7FFF, 16'h7FFF, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst done", 32'(done), 32'd0);
    checkOutput("midrst sum", 32'(sum), 32'd0);
    checkOutput("midrst cout", 32'(cout), 32'd0);
    checkOutput("midrst overflow", 32'(overflow), 32'd0);
    countDones(10, seen);
    checkOutput("midrst no done", 32'(seen), 32'd0);
    runAdd("after rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that adds two `4*NIBBLES`-bit operands one nibble per clock. It instantiates the team's 4-bit ripple-carry adder (`full_adder` chain, `a`/`b`/`cin` → `sum`/`cout`) as its only arithmetic element. The block sits directly around that adder. It feeds it nibble operands from shift registers, registers the inter-nibble carry, and collects each 4-bit sum into a result register. It trades latency for area wherever a full-width ripple chain is too long.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices; operand width `W = 4*NIBBLES`; legal range 1..16.
- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when the block is not busy.
- `a`  in  W  operand A; captured on an accepted start.
- `b`  in  W  operand B; captured on an accepted start.
- `cin`  in  1  carry-in to nibble 0; captured on an accepted start.
- `busy`  out  1  high while a sum is in progress.
- `done`  out  1  one-cycle pulse when the outputs below become valid.
- `sum`  out  W  result; held stable from `done` until the next accepted start.
- `cout`  out  1  carry out of the top nibble.
- `overflow`  out  1  two's-complement overflow of the W-bit signed add.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**: when `start=1`, capture `a`, `b` into shift registers `sa`, `sb`, and `cin` into carry register `cr`. Clear nibble counter `k` to 0. Latch `a[W-1]`, `b[W-1]` for the overflow calculation. Go to RUN.
- **RUN**, each cycle:
  - Adder inputs are `sa[3:0]`, `sb[3:0]`, `cr`.
  - The adder sum nibble shifts into the result register from the top: `res <= {sum4, res[W-1:4]}`.
  - `cr <= cout4`.
  - `sa` and `sb` shift right by 4.
  - `k` increments.
  - On the cycle where `k == NIBBLES-1`, go to DONE.
- **DONE**: update `sum`, `cout`, and `overflow` from `res` and `cr` on entry. `done=1` for exactly this cycle.
  - `start=1` in DONE is accepted exactly as in IDLE and goes straight to RUN, giving back-to-back operation.
  - Otherwise go to IDLE.
- `start` is ignored while in RUN, with no queuing and no effect on the operation in flight.
- `overflow = (a_msb == b_msb) && (sum[W-1] != a_msb)`, using the latched MSBs.
- `cout` is the carry registered after the final nibble. The arithmetic is mod 2^W, with `{cout,sum} = a + b + cin` exactly.
- `busy = (state == RUN)`.
- The outputs `sum`, `cout`, and `overflow` are separate output registers, not `res`. They change only on entry to DONE.
- Reset at any time, including mid-RUN:
  - Next state is IDLE, and the operation in flight is discarded.
  - `busy=0`, `done=0`, `sum=0`, `cout=0`, `overflow=0`.
  - The internal registers `sa`, `sb`, `res`, `cr`, and `k` clear to 0.
  - `rst` takes priority over `start` in the same cycle.

## Timing
- Cycle 0 is the edge where `start` is accepted.
- `busy` is high during cycles 1..NIBBLES.
- `done` is high in cycle NIBBLES+1, and `sum`/`cout`/`overflow` are valid in that same cycle.
- Latency from start to done is NIBBLES+1 cycles. Throughput is one add per NIBBLES+1 cycles with back-to-back starts.
- With `NIBBLES=1`: RUN lasts one cycle and `done` appears in cycle 2.
- The only combinational path is one 4-bit ripple adder, from registers to registers. There are no combinational paths from inputs to outputs.
- After reset deasserts, `start` is accepted in the first cycle with `rst=0`.

## Test plan
- **Basic add** (NIBBLES=4): `a=0x1234`, `b=0x4321`, `cin=0`, start pulse → `busy` high for 4 cycles, then `done` pulse with `sum=0x5555`, `cout=0`, `overflow=0`. Outputs hold afterwards.
- **Full carry ripple**: `a=0xFFFF`, `b=0x0001`, `cin=0` → `sum=0x0000`, `cout=1`, `overflow=0`. Also `a=0xFFFF`, `b=0x0000`, `cin=1` → `sum=0x0000`, `cout=1`.
- **Signed overflow**:
  - `0x7FFF+0x0001` → `sum=0x8000`, `overflow=1`, `cout=0`.
  - `0x8000+0x8000` → `sum=0x0000`, `cout=1`, `overflow=1`.
- **Start while busy**: start `0x0001+0x0001`, then assert `start` with `a=0xAAAA` on cycles 1–3 → single `done` with `sum=0x0002`; no second done.
- **Back-to-back**: hold `start=1` with new operands `0x1000+0x0234` during the DONE cycle → next `done` exactly 5 cycles later with `sum=0x1234`.
- **Reset mid-operation**: assert `rst` in cycle 2 of a RUN → next cycle `busy=0`, `done=0`, `sum=0`, `cout=0`, `overflow=0`. No `done` appears afterwards, and a fresh start completes normally.
